// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one memory request per PC update, stall wait with timeout,
// and a one-entry pending buffer for PC updates that arrive mid-fetch.
module inst_fetch #(
    parameter int ADDR_W   = 64,
    parameter int INST_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_pc_addr,
    input  logic              i_pc_valid,
    output logic              o_imem_cen,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_stall,
    input  logic [INST_W-1:0] i_imem_rdata,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_valid,
    output logic              o_fetch_err,
    output logic              o_overrun,
    output logic              o_busy
);

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nx;
    logic              pend_v, pend_v_nx;
    logic [ADDR_W-1:0] pend_addr, pend_addr_nx;
    logic [ADDR_W-1:0] req_addr_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              valid_nx, err_nx, overrun_nx, capture;
    logic              src_v;
    logic [ADDR_W-1:0] src_addr;

    // The pending entry is always older than a same-cycle PC pulse, so it wins.
    assign src_v    = pend_v | i_pc_valid;
    assign src_addr = pend_v ? pend_addr : i_pc_addr;

    always_comb begin
        state_nx     = state;
        pend_v_nx    = pend_v;
        pend_addr_nx = pend_addr;
        req_addr_nx  = o_imem_addr;
        cnt_nx       = cnt;
        valid_nx     = 1'b0;
        err_nx       = 1'b0;
        overrun_nx   = o_overrun;
        capture      = 1'b0;

        case (state)
            IDLE: begin
                if (src_v) begin
                    if (pend_v) begin
                        pend_v_nx    = i_pc_valid;
                        pend_addr_nx = i_pc_valid ? i_pc_addr : pend_addr;
                    end
                    if (src_addr[1:0] != 2'b00) begin
                        err_nx = 1'b1;
                    end else begin
                        req_addr_nx = src_addr;
                        state_nx    = REQ;
                    end
                end
            end
            REQ: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (!i_imem_stall) begin
                    capture  = 1'b1;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == CNT_W'(MAX_WAIT - 1)) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state != IDLE && i_pc_valid) begin
            if (!pend_v) begin
                pend_v_nx    = 1'b1;
                pend_addr_nx = i_pc_addr;
            end else begin
                overrun_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            pend_v       <= 1'b0;
            pend_addr    <= '0;
            cnt          <= '0;
            o_imem_addr  <= '0;
            o_inst       <= '0;
            o_inst_pc    <= '0;
            o_inst_valid <= 1'b0;
            o_fetch_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= state_nx;
            pend_v       <= pend_v_nx;
            pend_addr    <= pend_addr_nx;
            cnt          <= cnt_nx;
            o_imem_addr  <= req_addr_nx;
            o_inst_valid <= valid_nx;
            o_fetch_err  <= err_nx;
            o_overrun    <= overrun_nx;
            if (capture) begin
                o_inst    <= i_imem_rdata;
                o_inst_pc <= o_imem_addr;
            end
        end
    end

    assign o_imem_cen = (state == REQ);
    assign o_busy     = (state != IDLE) | pend_v;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus queues expected requests, responses and
// cycle-tagged probes; a negedge monitor pops and compares them.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] pc_addr = '0;
    logic        pc_valid = 1'b0;
    logic        imem_cen;
    logic [63:0] imem_addr;
    logic        imem_stall;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        fetch_err;
    logic        overrun;
    logic        busy;

    inst_fetch #(.ADDR_W(64), .INST_W(32), .MAX_WAIT(15)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pc_addr(pc_addr), .i_pc_valid(pc_valid),
        .o_imem_cen(imem_cen), .o_imem_addr(imem_addr),
        .i_imem_stall(imem_stall), .i_imem_rdata(imem_rdata),
        .o_inst(inst), .o_inst_pc(inst_pc), .o_inst_valid(inst_valid),
        .o_fetch_err(fetch_err), .o_overrun(overrun), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed contents, programmable stall count per request.
    int stall_n = 0;
    int rem = 0;
    function automatic logic [31:0] mem_rd(input logic [63:0] a);
        if (a == 64'h100) return 32'h00A0_0093;
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction
    assign imem_rdata = mem_rd(imem_addr);
    assign imem_stall = (rem != 0);
    always @(posedge clk or posedge rst) begin
        if (rst) rem <= 0;
        else if (imem_cen) rem <= stall_n;
        else if (rem != 0) rem <= rem - 1;
    end

    typedef struct { bit err; logic [31:0] inst; logic [63:0] pc; int cyc; } resp_t;
    typedef struct { logic [63:0] addr; int cyc; } req_t;
    typedef struct { int cyc; int sig; logic [63:0] val; } probe_t;

    localparam int S_CEN = 0, S_VALID = 1, S_ERR = 2, S_OVR = 3, S_INST = 4,
                   S_IPC = 5, S_IADDR = 6, S_BUSY = 7;

    resp_t  exp_q[$];
    req_t   req_q[$];
    probe_t probe_q[$];
    bit     done = 1'b0;
    int     checks = 0;
    int     passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
    endtask

    function automatic logic [63:0] sig_val(input int s);
        case (s)
            S_CEN:   return {63'd0, imem_cen};
            S_VALID: return {63'd0, inst_valid};
            S_ERR:   return {63'd0, fetch_err};
            S_OVR:   return {63'd0, overrun};
            S_INST:  return {32'd0, inst};
            S_IPC:   return inst_pc;
            S_IADDR: return imem_addr;
            default: return {63'd0, busy};
        endcase
    endfunction

    always @(negedge clk) begin
        while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
            probe_t p;
            p = probe_q.pop_front();
            chk($sformatf("probe_sig%0d_c%0d", p.sig, p.cyc),
                (p.cyc == cyc) ? sig_val(p.sig) : 64'hBAD, p.val);
        end
        if (!rst) begin
            if (inst_valid && fetch_err) chk("valid_err_exclusive", 64'd1, 64'd0);
            if (imem_cen) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_cen_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    chk("req_addr", imem_addr, r.addr);
                    chk("req_cycle", 64'(cyc), 64'(r.cyc));
                end
            end
            if (inst_valid || fetch_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("resp_is_err", {63'd0, fetch_err}, {63'd0, e.err});
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    if (!e.err) begin
                        chk("resp_inst", {32'd0, inst}, {32'd0, e.inst});
                        chk("resp_pc", inst_pc, e.pc);
                    end
                end
            end
        end
        if (done) begin
            chk("leftover_resp", 64'(exp_q.size()), 64'd0);
            chk("leftover_req", 64'(req_q.size()), 64'd0);
            chk("leftover_probe", 64'(probe_q.size()), 64'd0);
            $display("%0d/%0d checks passed", passes, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_until(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [63:0] a, output int n);
        @(posedge clk);
        #1;
        pc_addr  = a;
        pc_valid = 1'b1;
        n        = cyc;
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
    endtask

    task automatic probe(input int c, input int s, input logic [63:0] v);
        probe_t p;
        p.cyc = c; p.sig = s; p.val = v;
        probe_q.push_back(p);
    endtask

    task automatic exp_req(input logic [63:0] a, input int c);
        req_t r;
        r.addr = a; r.cyc = c;
        req_q.push_back(r);
    endtask

    task automatic exp_inst(input logic [31:0] d, input logic [63:0] a, input int c);
        resp_t e;
        e.err = 1'b0; e.inst = d; e.pc = a; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input int c);
        resp_t e;
        e.err = 1'b1; e.inst = '0; e.pc = '0; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic probe_all_zero(input int c);
        for (int s = 0; s <= S_BUSY; s++) probe(c, s, 64'd0);
    endtask

    initial begin
        int n, m;
        probe_all_zero(1);
        wait_until(3);
        rst = 1'b0;

        // basic
        stall_n = 0;
        pulse(64'h100, n);
        exp_req(64'h100, n + 1);
        exp_inst(32'h00A0_0093, 64'h100, n + 3);
        probe(n + 1, S_BUSY, 64'd1);
        wait_until(n + 5);

        // four stall cycles
        stall_n = 4;
        pulse(64'h104, n);
        exp_req(64'h104, n + 1);
        exp_inst(32'hDEAD_0104, 64'h104, n + 7);
        probe(n + 1, S_BUSY, 64'd1);
        probe(n + 6, S_BUSY, 64'd1);
        probe(n + 7, S_BUSY, 64'd0);
        wait_until(n + 9);

        // back-to-back through the pending buffer
        stall_n = 0;
        pulse(64'h108, n);
        exp_req(64'h108, n + 1);
        exp_inst(32'hDEAD_0108, 64'h108, n + 3);
        pulse(64'h10C, m);
        exp_req(64'h10C, n + 4);
        exp_inst(32'hDEAD_010C, 64'h10C, n + 6);
        probe(n + 7, S_OVR, 64'd0);
        wait_until(n + 9);

        // overrun: third address dropped
        stall_n = 10;
        pulse(64'h110, n);
        exp_req(64'h110, n + 1);
        exp_inst(32'hDEAD_0110, 64'h110, n + 13);
        pulse(64'h114, m);
        probe(n + 4, S_OVR, 64'd0);
        probe(n + 5, S_OVR, 64'd1);
        pulse(64'h118, m);
        exp_req(64'h114, n + 14);
        exp_inst(32'hDEAD_0114, 64'h114, n + 26);
        probe(n + 27, S_OVR, 64'd1);
        wait_until(n + 28);

        // misaligned address
        stall_n = 0;
        pulse(64'h102, n);
        exp_err(n + 1);
        probe(n + 2, S_BUSY, 64'd0);
        wait_until(n + 4);

        // timeout, then recovery
        stall_n = 100;
        pulse(64'h120, n);
        exp_req(64'h120, n + 1);
        exp_err(n + 17);
        probe(n + 16, S_BUSY, 64'd1);
        probe(n + 17, S_BUSY, 64'd0);
        wait_until(n + 18);
        stall_n = 0;
        pulse(64'h124, m);
        exp_req(64'h124, m + 1);
        exp_inst(32'hDEAD_0124, 64'h124, m + 3);
        wait_until(m + 5);

        // reset mid-WAIT with pending loaded
        stall_n = 10;
        pulse(64'h130, n);
        exp_req(64'h130, n + 1);
        pulse(64'h134, m);
        probe_all_zero(n + 4);
        wait_until(n + 4);
        rst = 1'b1;
        wait_until(n + 6);
        rst = 1'b0;
        probe(n + 7, S_BUSY, 64'd0);
        wait_until(n + 30);
        stall_n = 0;
        pulse(64'h138, n);
        exp_req(64'h138, n + 1);
        exp_inst(32'hDEAD_0138, 64'h138, n + 3);
        wait_until(n + 6);

        done = 1'b1;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the program counter. It consumes the PC's address and its one-cycle valid pulse, issues a single request to instruction memory, waits out memory stalls, and presents the returned instruction with its PC to the decoder as a one-cycle valid pulse. A one-entry pending buffer absorbs a PC update that arrives while a fetch is in flight; a bounded wait counter catches hung memory.

## Interface
- ADDR_W, 64, address width (matches PC output)
- INST_W, 32, instruction width
- MAX_WAIT, 15, max WAIT cycles with stall high before timeout (≤31)

- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_pc_addr  in  ADDR_W  fetch address from PC
- i_pc_valid  in  1  one-cycle pulse: i_pc_addr is new
- o_imem_cen  out  1  memory request strobe, exactly one cycle per fetch
- o_imem_addr  out  ADDR_W  request address, held from REQ until next request
- i_imem_stall  in  1  memory busy; rdata valid in a WAIT cycle where it is 0
- i_imem_rdata  in  INST_W  instruction data
- o_inst  out  INST_W  fetched instruction, held until next fetch completes
- o_inst_pc  out  ADDR_W  address of o_inst
- o_inst_valid  out  1  one-cycle pulse: o_inst/o_inst_pc updated
- o_fetch_err  out  1  one-cycle pulse: misaligned address or timeout
- o_overrun  out  1  sticky: PC update dropped (pending full); cleared only by reset
- o_busy  out  1  combinational: state != IDLE or pending valid

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: select source: pending entry if valid (clears it), else i_pc_valid/i_pc_addr. No source -> stay.
  - Selected addr[1:0] != 0 -> o_fetch_err pulse next cycle, no request, stay IDLE.
  - Else req_addr <= addr -> REQ.
- REQ: o_imem_cen=1, o_imem_addr=req_addr; wait counter <= 0 -> WAIT.
- WAIT: i_imem_stall=0 -> o_inst <= i_imem_rdata, o_inst_pc <= req_addr, o_inst_valid pulse next cycle -> IDLE.
  - i_imem_stall=1: counter +1; counter reaches MAX_WAIT -> o_fetch_err pulse, no o_inst_valid, -> IDLE.
- Pending buffer (one entry, pend_v/pend_addr):
  - i_pc_valid while not IDLE: pend empty -> load; full -> keep oldest, drop new, set o_overrun.
  - i_pc_valid in IDLE while pend_v=1: pend issued, new address loads pend in same edge (no overrun).
- o_imem_cen never high outside REQ; rdata ignored outside WAIT.

## Timing
- Reset (async assert): state IDLE, pend_v=0, counter=0; all outputs 0 (o_inst, o_inst_pc, o_imem_addr, o_imem_cen, o_inst_valid, o_fetch_err, o_overrun).
- Reset mid-fetch: in-flight and pending fetches discarded; no o_inst_valid after release.
- Zero-stall latency: i_pc_valid cycle N (IDLE) -> o_imem_cen cycle N+1 -> WAIT cycle N+2 captures -> o_inst_valid cycle N+3.
- Each stall cycle adds one cycle. Timeout: o_fetch_err in the cycle after the MAX_WAIT-th stalled WAIT cycle.
- Pending fetch: o_imem_cen one cycle after return to IDLE (IDLE costs one cycle).
- Misaligned: o_fetch_err at N+1, o_busy low at N+1 if pend empty.
- o_inst_valid and o_fetch_err never high together.

## Test plan
- Basic: pc_valid, addr 0x100, stall 0, rdata 0x00A00093 -> cen at N+1 addr 0x100; o_inst_valid at N+3, o_inst=0x00A00093, o_inst_pc=0x100.
- Stall: addr 0x104, stall high 4 WAIT cycles -> o_inst_valid at N+7; o_busy high N+1..N+6.
- Back-to-back: 0x108 at N, 0x10C at N+2 (stall 0) -> two fetches in order, second cen at N+4, no overrun.
- Overrun: 0x110 at N with stall 10, 0x114 at N+2, 0x118 at N+4 -> 0x110 then 0x114 fetched; 0x118 never requested; o_overrun=1 from N+5.
- Errors: addr 0x102 -> o_fetch_err at N+1, no cen; stall held high -> o_fetch_err after 15 WAIT cycles, no o_inst_valid, next fetch succeeds.
- Reset mid-WAIT with pending loaded -> outputs 0 immediately; after release no cen/o_inst_valid until a new pc_valid.
